// File: rtl/spi_periph_bridge.sv
// SPI (mode 0) peripheral to register-bus bridge: 16-bit frames {rw, 3'bx, addr[3:0], data[7:0]}.
// Writes pulse reg_write after the 16th bit; reads return reg_rdata[addr] MSB first on bits 9..16.
module spi_periph_bridge (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_cs_n,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [3:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_write,
    input  logic [7:0] reg_rdata
);

    // IDLE: no frame | CMD: bits 1..8 | DATA: bits 9..16 | DONE: frame complete, wait for cs_n high
    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t      state_q, state_d;
    logic        sclk_prev_q, cs_prev_q;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic        is_write_q, is_write_d;
    logic        load_tx_q, load_tx_d;
    logic        miso_en_q, miso_en_d;
    logic [3:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        sclk_rise, sclk_fall;

    assign sclk_rise = spi_clk & ~sclk_prev_q;
    assign sclk_fall = ~spi_clk & sclk_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            bit_cnt_q   <= 5'd0;
            rx_q        <= 8'd0;
            tx_q        <= 8'd0;
            is_write_q  <= 1'b0;
            load_tx_q   <= 1'b0;
            miso_en_q   <= 1'b0;
            addr_q      <= 4'd0;
            wdata_q     <= 8'd0;
            write_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_prev_q <= spi_clk;
            cs_prev_q   <= spi_cs_n;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            is_write_q  <= is_write_d;
            load_tx_q   <= load_tx_d;
            miso_en_q   <= miso_en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        is_write_d = is_write_q;
        load_tx_d  = 1'b0;
        miso_en_d  = miso_en_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_d    = 1'b0;

        if (load_tx_q) begin
            tx_d = reg_rdata;
        end

        if (spi_cs_n) begin
            state_d   = IDLE;
            bit_cnt_d = 5'd0;
            miso_en_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    bit_cnt_d = 5'd0;
                    miso_en_d = 1'b0;
                    // cs_prev_q resets low, so cs_n held low across reset release never starts a frame
                    if (cs_prev_q) begin
                        state_d = CMD;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        rx_d      = {rx_q[6:0], spi_mosi};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            addr_d     = {rx_q[2:0], spi_mosi};
                            is_write_d = rx_q[6];
                            load_tx_d  = ~rx_q[6];
                            state_d    = DATA;
                        end
                    end
                end
                DATA: begin
                    if (sclk_fall && !is_write_q) begin
                        if (miso_en_q) begin
                            tx_d = {tx_q[6:0], 1'b0};
                        end
                        miso_en_d = 1'b1;
                    end
                    if (sclk_rise) begin
                        rx_d      = {rx_q[6:0], spi_mosi};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd15) begin
                            state_d = DONE;
                            if (is_write_q) begin
                                wdata_d = {rx_q[6:0], spi_mosi};
                                write_d = 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign spi_miso  = (state_q == DATA) && miso_en_q && !is_write_q && tx_q[7];
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_write = write_q;

endmodule

// File: tb/tb_spi_periph_bridge.sv
// Directed bench for spi_periph_bridge: bit-banged SPI master plus a small register-file model.
module tb_spi_periph_bridge;

    localparam int HP = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_cs_n;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_write;
    logic [7:0] reg_rdata;

    logic [7:0] mem [16];
    assign reg_rdata = mem[reg_addr];

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int last_wr_cyc = 0;
    int rise16_cyc = 0;
    logic [3:0]  wr_addr_q [$];
    logic [7:0]  wr_data_q [$];
    logic [15:0] miso_vec;

    spi_periph_bridge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_cs_n  (spi_cs_n),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_write (reg_write),
        .reg_rdata (reg_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && reg_write) begin
            wr_cnt = wr_cnt + 1;
            last_wr_cyc = cyc;
            wr_addr_q.push_back(reg_addr);
            wr_data_q.push_back(reg_wdata);
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clock bits [first, first+n) of w; bits past 15 send 0. MISO is sampled just before each rise.
    task automatic spi_bits(input logic [15:0] w, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            spi_mosi = (i < 16) ? w[15-i] : 1'b0;
            wait_clks(HP);
            if (i < 16) miso_vec[15-i] = spi_miso;
            spi_clk = 1'b1;
            if (i == 15) rise16_cyc = cyc;
            wait_clks(HP);
            spi_clk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [15:0] w, input int n, input int gap);
        miso_vec = 16'hxxxx;
        spi_cs_n = 1'b0;
        wait_clks(HP);
        spi_bits(w, 0, n);
        wait_clks(HP);
        spi_cs_n = 1'b1;
        wait_clks(gap);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        spi_cs_n = 1'b1;
        spi_clk = 1'b0;
        spi_mosi = 1'b0;
        wait_clks(3);
        tests_run++;
        if (reg_addr !== 4'h0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", reg_addr); end
        tests_run++;
        if (reg_wdata !== 8'h00) begin tests_failed++; $display("FAIL reset_wdata: got %h want 00", reg_wdata); end
        tests_run++;
        if (reg_write !== 1'b0) begin tests_failed++; $display("FAIL reset_write: got %b want 0", reg_write); end
        tests_run++;
        if (spi_miso !== 1'b0) begin tests_failed++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
        rst_n = 1'b1;
        wait_clks(3);
    endtask

    task automatic test_write();
        int n0 = wr_cnt;
        spi_frame(16'h83A5, 16, 3);
        tests_run++;
        if (wr_cnt - n0 !== 1) begin tests_failed++; $display("FAIL write_count: got %0d want 1", wr_cnt - n0); end
        tests_run++;
        if (last_wr_cyc !== rise16_cyc + 1) begin tests_failed++; $display("FAIL write_timing: pulse cyc %0d want %0d", last_wr_cyc, rise16_cyc + 1); end
        tests_run++;
        if (reg_addr !== 4'h3) begin tests_failed++; $display("FAIL write_addr: got %h want 3", reg_addr); end
        tests_run++;
        if (reg_wdata !== 8'hA5) begin tests_failed++; $display("FAIL write_data: got %h want A5", reg_wdata); end
        tests_run++;
        if (miso_vec !== 16'h0000) begin tests_failed++; $display("FAIL write_miso: got %h want 0000", miso_vec); end
    endtask

    task automatic test_read();
        int n0 = wr_cnt;
        spi_frame(16'h0700, 16, 3);
        tests_run++;
        if (miso_vec !== 16'h00C3) begin tests_failed++; $display("FAIL read_miso: got %h want 00C3", miso_vec); end
        tests_run++;
        if (reg_addr !== 4'h7) begin tests_failed++; $display("FAIL read_addr: got %h want 7", reg_addr); end
        tests_run++;
        if (wr_cnt - n0 !== 0) begin tests_failed++; $display("FAIL read_nowrite: got %0d pulses want 0", wr_cnt - n0); end
        tests_run++;
        if (spi_miso !== 1'b0) begin tests_failed++; $display("FAIL read_idle_miso: got %b want 0", spi_miso); end
    endtask

    task automatic test_abort();
        int n0 = wr_cnt;
        spi_frame(16'h855A, 12, 3);
        tests_run++;
        if (wr_cnt - n0 !== 0) begin tests_failed++; $display("FAIL abort_nowrite: got %0d pulses want 0", wr_cnt - n0); end
        tests_run++;
        if (reg_wdata !== 8'hA5) begin tests_failed++; $display("FAIL abort_wdata: got %h want A5", reg_wdata); end
        tests_run++;
        if (reg_addr !== 4'h5) begin tests_failed++; $display("FAIL abort_addr: got %h want 5", reg_addr); end
    endtask

    task automatic test_extra_bits();
        int n0 = wr_cnt;
        spi_frame(16'h843C, 20, 3);
        tests_run++;
        if (wr_cnt - n0 !== 1) begin tests_failed++; $display("FAIL extra_count: got %0d want 1", wr_cnt - n0); end
        tests_run++;
        if (reg_wdata !== 8'h3C) begin tests_failed++; $display("FAIL extra_data: got %h want 3C", reg_wdata); end
        tests_run++;
        if (reg_addr !== 4'h4) begin tests_failed++; $display("FAIL extra_addr: got %h want 4", reg_addr); end
    endtask

    task automatic test_back_to_back();
        int n0 = wr_cnt;
        int q0 = wr_addr_q.size();
        spi_frame(16'h8101, 16, 1);
        spi_frame(16'h8FFF, 16, 3);
        tests_run++;
        if (wr_cnt - n0 !== 2) begin tests_failed++; $display("FAIL b2b_count: got %0d want 2", wr_cnt - n0); end
        if (wr_addr_q.size() >= q0 + 2) begin
            tests_run++;
            if (wr_addr_q[q0] !== 4'h1 || wr_data_q[q0] !== 8'h01) begin
                tests_failed++; $display("FAIL b2b_first: got %h/%h want 1/01", wr_addr_q[q0], wr_data_q[q0]);
            end
            tests_run++;
            if (wr_addr_q[q0+1] !== 4'hF || wr_data_q[q0+1] !== 8'hFF) begin
                tests_failed++; $display("FAIL b2b_second: got %h/%h want F/FF", wr_addr_q[q0+1], wr_data_q[q0+1]);
            end
        end
    endtask

    task automatic test_cs_same_cycle();
        int n0 = wr_cnt;
        logic [15:0] w = 16'h8E55;
        spi_cs_n = 1'b0;
        wait_clks(HP);
        spi_bits(w, 0, 15);
        spi_mosi = w[0];
        wait_clks(HP);
        spi_clk = 1'b1;
        spi_cs_n = 1'b1;
        wait_clks(HP);
        spi_clk = 1'b0;
        wait_clks(3);
        tests_run++;
        if (wr_cnt - n0 !== 0) begin tests_failed++; $display("FAIL cs16_nowrite: got %0d pulses want 0", wr_cnt - n0); end
        tests_run++;
        if (reg_wdata !== 8'hFF) begin tests_failed++; $display("FAIL cs16_wdata: got %h want FF", reg_wdata); end
        tests_run++;
        if (reg_addr !== 4'hE) begin tests_failed++; $display("FAIL cs16_addr: got %h want E", reg_addr); end
    endtask

    task automatic test_reset_mid_frame();
        int n0;
        logic [15:0] w = 16'h8677;
        spi_cs_n = 1'b0;
        wait_clks(HP);
        spi_bits(w, 0, 10);
        rst_n = 1'b0;
        wait_clks(1);
        tests_run++;
        if (reg_addr !== 4'h0 || reg_wdata !== 8'h00) begin
            tests_failed++; $display("FAIL midrst_regs: got %h/%h want 0/00", reg_addr, reg_wdata);
        end
        wait_clks(2);
        rst_n = 1'b1;
        n0 = wr_cnt;
        spi_bits(w, 10, 6);
        wait_clks(HP);
        tests_run++;
        if (wr_cnt - n0 !== 0) begin tests_failed++; $display("FAIL midrst_stale: got %0d pulses want 0", wr_cnt - n0); end
        spi_cs_n = 1'b1;
        wait_clks(2);
        spi_frame(16'h8211, 16, 3);
        tests_run++;
        if (wr_cnt - n0 !== 1) begin tests_failed++; $display("FAIL midrst_count: got %0d want 1", wr_cnt - n0); end
        tests_run++;
        if (reg_addr !== 4'h2 || reg_wdata !== 8'h11) begin
            tests_failed++; $display("FAIL midrst_write: got %h/%h want 2/11", reg_addr, reg_wdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[7] = 8'hC3;
        miso_vec = 16'h0000;
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_extra_bits();
        test_back_to_back();
        test_cs_same_cycle();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
